// File: rtl/cs_lifo_pkg.sv
// cs_lifo_pkg: shared types and defaults for the clip-and-split LIFO
//   Triangle3D    : packed triangle record (three xyz vertices, 16 bits per axis)
//   TRI3D_W       : width of a Triangle3D in bits
//   CS_STACK_LOG2 : default log2 of the stack depth
package cs_lifo_pkg;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } vertex3d_t;

    typedef struct packed {
        vertex3d_t v0;
        vertex3d_t v1;
        vertex3d_t v2;
    } Triangle3D;

    localparam int TRI3D_W       = $bits(Triangle3D);
    localparam int CS_STACK_LOG2 = 3;

endpackage

// File: rtl/cs_lifo_mem.sv
// cs_lifo_mem: DEPTH x WIDTH register file, one sync write port, one async read port
//   clk      : clock, rising edge
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational; shows the old contents when the same
//              address is written in this cycle)
module cs_lifo_mem
    import cs_lifo_pkg::*;
#(
    parameter int WIDTH      = TRI3D_W,
    parameter int DEPTH_LOG2 = CS_STACK_LOG2
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cs_lifo.sv
// cs_lifo: newest-first stack with push+pop replace, occupancy, high-water mark, flush and error pulses
//   clk          : clock, rising edge
//   n_rst        : asynchronous active-low reset
//   flush_i      : discard all entries (overrides push/pop)
//   push_i/din_i : write din_i onto top of stack
//   pop_i        : remove top entry; it appears on dout_o the next cycle
//   dout_o       : last popped entry, held until the next accepted pop
//   dout_valid_o : one-cycle pulse, dout_o updated
//   count_o      : occupancy 0..DEPTH
//   hwm_o        : highest occupancy since reset/flush
//   empty_o      : count_o == 0
//   full_o       : count_o == DEPTH
//   overflow_o   : one-cycle pulse, push rejected
//   underflow_o  : one-cycle pulse, pop rejected
module cs_lifo
    import cs_lifo_pkg::*;
#(
    parameter int WIDTH      = TRI3D_W,
    parameter int DEPTH_LOG2 = CS_STACK_LOG2
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      din_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      dout_o,
    output logic                  dout_valid_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic [DEPTH_LOG2:0]   hwm_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int CW = DEPTH_LOG2 + 1;
    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CW-1:0]    count_q, count_d, hwm_q, hwm_d, top_c;
    logic [WIDTH-1:0] dout_q, dout_d, rdata;
    logic             valid_q, valid_d, ovf_q, ovf_d, udf_q, udf_d;
    logic             we;
    logic [DEPTH_LOG2-1:0] waddr;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == FULL_CNT;
    assign top_c   = count_q - ONE;

    // push+pop on a non-empty stack overwrites the top slot; a lone push appends
    assign waddr = pop_i ? top_c[DEPTH_LOG2-1:0] : count_q[DEPTH_LOG2-1:0];

    cs_lifo_mem #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_mem (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (din_i),
        .raddr_i (top_c[DEPTH_LOG2-1:0]),
        .rdata_o (rdata)
    );

    always_comb begin
        count_d = count_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        we      = 1'b0;
        if (flush_i) begin
            count_d = '0;
        end else if (push_i && pop_i) begin
            valid_d = 1'b1;
            we      = !empty_o;
            // empty stack: the pushed entry passes straight through
            dout_d  = empty_o ? din_i : rdata;
        end else if (push_i) begin
            ovf_d   = full_o;
            we      = !full_o;
            count_d = full_o ? count_q : count_q + ONE;
        end else if (pop_i) begin
            udf_d   = empty_o;
            valid_d = !empty_o;
            dout_d  = empty_o ? dout_q : rdata;
            count_d = empty_o ? count_q : top_c;
        end
        hwm_d = flush_i ? '0 : (count_d > hwm_q ? count_d : hwm_q);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            hwm_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            hwm_q   <= hwm_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign count_o      = count_q;
    assign hwm_o        = hwm_q;
    assign overflow_o   = ovf_q;
    assign underflow_o  = udf_q;

endmodule

// File: tb/tb_cs_lifo.sv
// tb_cs_lifo: directed self-checking bench for cs_lifo
module tb_cs_lifo;
    import cs_lifo_pkg::*;

    localparam int W = TRI3D_W;

    logic         clk, n_rst, flush, push, pop;
    logic [W-1:0] din, dout;
    logic         dout_valid, empty, full, overflow, underflow;
    logic [3:0]   count, hwm;
    int           checks, errors;

    cs_lifo dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .flush_i      (flush),
        .push_i       (push),
        .din_i        (din),
        .pop_i        (pop),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .count_o      (count),
        .hwm_o        (hwm),
        .empty_o      (empty),
        .full_o       (full),
        .overflow_o   (overflow),
        .underflow_o  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] tv(input logic [15:0] v);
        return {(W/16){v}};
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0;
        pop = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n_rst = 1'b0;
        din = '0;
        idle();
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        chk("rst_count", int'(count), 0);
        chk("rst_hwm", int'(hwm), 0);
        chk_d("rst_dout", dout, '0);
        chk("rst_valid", int'(dout_valid), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_udf", int'(underflow), 0);

        // push A,B,C then pop three times
        push = 1'b1;
        din = tv(16'h000A); tick();
        din = tv(16'h000B); tick();
        din = tv(16'h000C); tick();
        push = 1'b0;
        chk("t1_count3", int'(count), 3);
        chk("t1_hwm3", int'(hwm), 3);
        pop = 1'b1;
        tick();
        chk_d("t1_pop_c", dout, tv(16'h000C));
        chk("t1_valid_c", int'(dout_valid), 1);
        chk("t1_count2", int'(count), 2);
        tick();
        chk_d("t1_pop_b", dout, tv(16'h000B));
        chk("t1_valid_b", int'(dout_valid), 1);
        tick();
        chk_d("t1_pop_a", dout, tv(16'h000A));
        chk("t1_valid_a", int'(dout_valid), 1);
        chk("t1_count0", int'(count), 0);
        pop = 1'b0;
        tick();
        chk("t1_valid_off", int'(dout_valid), 0);
        chk("t1_empty", int'(empty), 1);
        chk("t1_hwm_held", int'(hwm), 3);
        chk_d("t1_dout_held", dout, tv(16'h000A));

        // fill to 8, reject 9th, then replace top
        push = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            din = tv(16'h0010 + 16'(i));
            tick();
        end
        chk("t2_full", int'(full), 1);
        chk("t2_count8", int'(count), 8);
        chk("t2_hwm8", int'(hwm), 8);
        chk("t2_no_ovf", int'(overflow), 0);
        din = tv(16'h0019);
        tick();
        chk("t2_ovf", int'(overflow), 1);
        chk("t2_count_hold", int'(count), 8);
        push = 1'b0;
        tick();
        chk("t2_ovf_pulse", int'(overflow), 0);
        push = 1'b1;
        pop = 1'b1;
        din = tv(16'h00EE);
        tick();
        chk_d("t2_repl_dout", dout, tv(16'h0018));
        chk("t2_repl_valid", int'(dout_valid), 1);
        chk("t2_repl_count", int'(count), 8);
        chk("t2_repl_no_ovf", int'(overflow), 0);
        push = 1'b0;
        tick();
        chk_d("t2_pop_x", dout, tv(16'h00EE));
        chk("t2_count7", int'(count), 7);
        pop = 1'b0;
        flush = 1'b1;
        tick();
        chk("t2_flush_count", int'(count), 0);
        chk("t2_flush_hwm", int'(hwm), 0);
        chk("t2_flush_valid", int'(dout_valid), 0);
        chk_d("t2_flush_dout", dout, tv(16'h00EE));

        // pop on empty
        flush = 1'b0;
        pop = 1'b1;
        tick();
        chk("t3_udf", int'(underflow), 1);
        chk("t3_valid", int'(dout_valid), 0);
        chk_d("t3_dout_held", dout, tv(16'h00EE));
        pop = 1'b0;
        tick();
        chk("t3_udf_pulse", int'(underflow), 0);

        // push+pop on empty bypasses
        push = 1'b1;
        pop = 1'b1;
        din = tv(16'h00DD);
        tick();
        chk_d("t4_bypass_dout", dout, tv(16'h00DD));
        chk("t4_bypass_valid", int'(dout_valid), 1);
        chk("t4_bypass_count", int'(count), 0);
        chk("t4_no_udf", int'(underflow), 0);
        chk("t4_no_ovf", int'(overflow), 0);
        chk("t4_hwm", int'(hwm), 0);

        // push 5, then flush together with push
        pop = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            din = tv(16'h0050 + 16'(i));
            tick();
        end
        chk("t5_count5", int'(count), 5);
        chk("t5_hwm5", int'(hwm), 5);
        flush = 1'b1;
        din = tv(16'h0056);
        tick();
        chk("t5_count0", int'(count), 0);
        chk("t5_hwm0", int'(hwm), 0);
        chk("t5_empty", int'(empty), 1);
        chk("t5_no_ovf", int'(overflow), 0);
        chk("t5_no_udf", int'(underflow), 0);
        idle();

        // async reset mid-cycle
        push = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            din = tv(16'h0060 + 16'(i));
            tick();
        end
        push = 1'b0;
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk_d("t6_pre_dout", dout, tv(16'h0064));
        chk("t6_pre_count", int'(count), 3);
        #2;
        n_rst = 1'b0;
        #1;
        chk("t6_rst_count", int'(count), 0);
        chk("t6_rst_hwm", int'(hwm), 0);
        chk_d("t6_rst_dout", dout, '0);
        chk("t6_rst_valid", int'(dout_valid), 0);
        chk("t6_rst_empty", int'(empty), 1);
        n_rst = 1'b1;
        pop = 1'b1;
        tick();
        chk("t6_udf", int'(underflow), 1);
        chk("t6_valid", int'(dout_valid), 0);
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
